// File: rtl/audio_pkg.sv
// Shared definitions for the audio mix stage: output mode encodings and default widths.
package audio_pkg;

  typedef enum logic [1:0] {
    MODE_MIX  = 2'b00,
    MODE_DRY  = 2'b01,
    MODE_WET  = 2'b10,
    MODE_MUTE = 2'b11
  } mix_mode_e;

  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_DATA_W = 24;
  localparam int unsigned DEF_COEF_W = 24;

endpackage

// File: rtl/audio_mix_stage_if.sv
// Frame bus of the mix stage: lockstep dry/wet sample input and mixed sample output.
interface audio_mix_stage_if
  import audio_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [NUM_CH*DATA_W-1:0] dry_data;
  logic [NUM_CH-1:0]        dry_valid;
  logic [NUM_CH*DATA_W-1:0] wet_data;
  logic [NUM_CH-1:0]        wet_valid;
  logic                     sink_ready;
  logic [NUM_CH*DATA_W-1:0] src_data;
  logic                     src_valid;
  logic                     src_ready;

  modport master (
    output dry_data, dry_valid, wet_data, wet_valid, src_ready,
    input  sink_ready, src_data, src_valid
  );

  modport slave (
    input  dry_data, dry_valid, wet_data, wet_valid, src_ready,
    output sink_ready, src_data, src_valid
  );
endinterface

// File: rtl/audio_mix_lane.sv
// One channel of the mixer: S1 registers weighted products, S2 registers the
// rounded, clamped sum.
module audio_mix_lane
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned COEF_W = DEF_COEF_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s1_load_i,
  input  logic              s2_load_i,
  input  logic [DATA_W-1:0] dry_i,
  input  logic [DATA_W-1:0] wet_i,
  input  logic [COEF_W:0]   dry_fac_i,
  input  logic [COEF_W:0]   wet_fac_i,
  output logic [DATA_W-1:0] out_o
);
  localparam int unsigned P = DATA_W + COEF_W + 2;

  localparam logic signed [P-1:0] RND   = {{(P-COEF_W){1'b0}}, 1'b1, {(COEF_W-1){1'b0}}};
  localparam logic signed [P-1:0] MAX_V = {{(P-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [P-1:0] MIN_V = {{(P-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [P-1:0] dry_x, wet_x, dfac_x, wfac_x;
  logic signed [P-1:0] prod_dry_d, prod_wet_d, prod_dry_q, prod_wet_q;
  logic signed [P-1:0] sum, shifted;
  logic [DATA_W-1:0]   out_d, out_q;

  always_comb begin
    dry_x      = {{(P-DATA_W){dry_i[DATA_W-1]}}, dry_i};
    wet_x      = {{(P-DATA_W){wet_i[DATA_W-1]}}, wet_i};
    dfac_x     = {{(P-COEF_W-1){1'b0}}, dry_fac_i};
    wfac_x     = {{(P-COEF_W-1){1'b0}}, wet_fac_i};
    prod_dry_d = dry_x * dfac_x;
    prod_wet_d = wet_x * wfac_x;
  end

  always_comb begin
    sum     = prod_dry_q + prod_wet_q + RND;
    shifted = sum >>> COEF_W;
    if (shifted > MAX_V) begin
      out_d = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      out_d = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      out_d = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_dry_q <= '0;
      prod_wet_q <= '0;
      out_q      <= '0;
    end else begin
      if (s1_load_i) begin
        prod_dry_q <= prod_dry_d;
        prod_wet_q <= prod_wet_d;
      end
      if (s2_load_i) begin
        out_q <= out_d;
      end
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/audio_mix_stage.sv
// Two-stage dry/wet audio mixer with a shared frame handshake across NUM_CH lanes
// and a loadable wet-mix coefficient.
module audio_mix_stage
  import audio_pkg::*;
#(
  parameter int unsigned       NUM_CH  = DEF_NUM_CH,
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter int unsigned       COEF_W  = DEF_COEF_W,
  parameter logic [COEF_W-1:0] MIX_RST = {1'b1, {(COEF_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              reset_n,
  audio_mix_stage_if.slave  bus,
  input  logic [COEF_W-1:0] mix_value,
  input  logic              mix_load,
  input  logic [1:0]        mode
);
  localparam logic [COEF_W:0] UNITY = {1'b1, {COEF_W{1'b0}}};

  logic [COEF_W-1:0]        mix_q;
  logic                     s1_valid_q, s1_valid_d;
  logic                     src_valid_q, src_valid_d;
  logic                     stall, accept, s2_load;
  logic [COEF_W:0]          dry_fac, wet_fac;
  logic [NUM_CH*DATA_W-1:0] src_data;
  mix_mode_e                mode_e;

  assign stall          = src_valid_q & ~bus.src_ready;
  assign bus.sink_ready = reset_n & ~stall;
  assign accept         = bus.sink_ready & (&bus.dry_valid) & (&bus.wet_valid);
  assign s2_load        = s1_valid_q & ~stall;
  assign mode_e         = mix_mode_e'(mode);

  // Every mode is expressed as a pair of weights on the shared datapath, so
  // bypass/wet/mute come out exact through the rounding shift at equal latency.
  always_comb begin
    dry_fac = '0;
    wet_fac = '0;
    case (mode_e)
      MODE_MIX: begin
        dry_fac = UNITY - {1'b0, mix_q};
        wet_fac = {1'b0, mix_q};
      end
      MODE_DRY: dry_fac = UNITY;
      MODE_WET: wet_fac = UNITY;
      default:  ;
    endcase
  end

  always_comb begin
    s1_valid_d  = stall ? s1_valid_q : accept;
    src_valid_d = stall ? src_valid_q : s1_valid_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mix_q       <= MIX_RST;
      s1_valid_q  <= 1'b0;
      src_valid_q <= 1'b0;
    end else begin
      if (mix_load) begin
        mix_q <= mix_value;
      end
      s1_valid_q  <= s1_valid_d;
      src_valid_q <= src_valid_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    audio_mix_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .s1_load_i (accept),
      .s2_load_i (s2_load),
      .dry_i     (bus.dry_data[g*DATA_W +: DATA_W]),
      .wet_i     (bus.wet_data[g*DATA_W +: DATA_W]),
      .dry_fac_i (dry_fac),
      .wet_fac_i (wet_fac),
      .out_o     (src_data[g*DATA_W +: DATA_W])
    );
  end

  assign bus.src_data  = src_data;
  assign bus.src_valid = src_valid_q;

endmodule

// File: tb/tb_audio_mix_stage.sv
// Scoreboard bench for audio_mix_stage: randomized and directed frames checked
// against an arithmetic reference of the mix rules.
module tb_audio_mix_stage;
  import audio_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 24;
  localparam int unsigned CW  = 24;
  localparam logic [CW-1:0] MIX_DEFAULT = 24'h800000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] mix_value;
  logic          mix_load;
  logic [1:0]    mode;

  always #5 clk = ~clk;

  audio_mix_stage_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  audio_mix_stage #(
    .NUM_CH (NCH),
    .DATA_W (DW),
    .COEF_W (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mix_value (mix_value),
    .mix_load  (mix_load),
    .mode      (mode)
  );

  logic [NCH*DW-1:0] exp_q[$];
  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  int unsigned       n_out = 0;
  logic [CW-1:0]     mix_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] ref_lane(input logic signed [DW-1:0] d,
                                              input logic signed [DW-1:0] w,
                                              input logic [1:0] m,
                                              input logic [CW-1:0] mix);
    longint dd, ww, mx, r;
    dd = d;
    ww = w;
    mx = longint'(mix);
    case (m)
      2'b00:   r = (dd * (64'sd16777216 - mx) + ww * mx + 64'sd8388608) >>> 24;
      2'b01:   r = dd;
      2'b10:   r = ww;
      default: r = 0;
    endcase
    if (r > 64'sd8388607)  r = 64'sd8388607;
    if (r < -64'sd8388608) r = -64'sd8388608;
    return r[DW-1:0];
  endfunction

  function automatic logic [NCH*DW-1:0] ref_frame(input logic [NCH*DW-1:0] dd,
                                                   input logic [NCH*DW-1:0] wd,
                                                   input logic [1:0] m,
                                                   input logic [CW-1:0] mix);
    logic [NCH*DW-1:0] v;
    for (int unsigned c = 0; c < NCH; c++)
      v[c*DW +: DW] = ref_lane(dd[c*DW +: DW], wd[c*DW +: DW], m, mix);
    return v;
  endfunction

  function automatic logic [DW-1:0] rsamp();
    case ($urandom_range(0, 5))
      0:       return 24'h800000;
      1:       return 24'h7fffff;
      2:       return 24'h000000;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [NCH*DW-1:0] rvec();
    logic [NCH*DW-1:0] v;
    for (int unsigned c = 0; c < NCH; c++) v[c*DW +: DW] = rsamp();
    return v;
  endfunction

  task automatic cycle(input logic [NCH-1:0] dv, input logic [NCH-1:0] wv,
                       input logic [NCH*DW-1:0] dd, input logic [NCH*DW-1:0] wd,
                       input logic [1:0] md, input logic ld, input logic [CW-1:0] mv,
                       input logic rdy, output logic acc);
    @(negedge clk);
    bus.dry_valid = dv;
    bus.wet_valid = wv;
    bus.dry_data  = dd;
    bus.wet_data  = wd;
    mode          = md;
    mix_load      = ld;
    mix_value     = mv;
    bus.src_ready = rdy;
    #1;
    check("sink_ready", 64'(bus.sink_ready), 64'(reset_n && !(bus.src_valid && !rdy)));
    acc = reset_n && bus.sink_ready && (&dv) && (&wv);
    if (acc) exp_q.push_back(ref_frame(dd, wd, md, mix_m));
    if (reset_n && ld) mix_m = mv;
  endtask

  task automatic idle(input logic rdy);
    logic a;
    cycle('0, '0, '0, '0, 2'b00, 1'b0, '0, rdy, a);
  endtask

  task automatic frame(input logic [NCH*DW-1:0] dd, input logic [NCH*DW-1:0] wd,
                       input logic [1:0] md, input logic ld, input logic [CW-1:0] mv);
    logic a;
    cycle('1, '1, dd, wd, md, ld, mv, 1'b1, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: every handshaken output frame must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1 && bus.src_valid === 1'b1 && bus.src_ready === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got frame %0h, required no frame", bus.src_data);
        end else begin
          check("src_data", 64'(bus.src_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic              a, held_v;
    logic [NCH*DW-1:0] dd, wd, held;
    int unsigned       n0, acc_cnt;

    reset_n = 1'b0;
    bus.dry_valid = '0; bus.wet_valid = '0; bus.dry_data = '0; bus.wet_data = '0;
    bus.src_ready = 1'b1; mix_value = '0; mix_load = 1'b0; mode = 2'b00;
    mix_m = MIX_DEFAULT;

    repeat (3) idle(1'b1);
    check("rst_src_valid", 64'(bus.src_valid), 64'(0));
    check("rst_src_data", 64'(bus.src_data), 64'(0));
    check("rst_sink_ready", 64'(bus.sink_ready), 64'(0));
    reset_n = 1'b1;
    idle(1'b1);

    // Half mix of +1000/+3000 with the reset coefficient, two-cycle latency.
    frame({24'd1000, 24'd1000}, {24'd3000, 24'd3000}, 2'b00, 1'b0, '0);
    idle(1'b1);
    check("lat_1cyc_valid", 64'(bus.src_valid), 64'(0));
    idle(1'b1);
    check("lat_2cyc_valid", 64'(bus.src_valid), 64'(1));
    check("half_mix_data", 64'(bus.src_data), 64'({24'd2000, 24'd2000}));
    idle(1'b1);

    // Full-scale extremes in every mode with mix=0.
    cycle('0, '0, '0, '0, 2'b00, 1'b1, '0, 1'b1, a);
    dd = {2{24'h800000}};
    wd = {2{24'h7fffff}};
    for (int m = 0; m < 4; m++) frame(dd, wd, 2'(m), 1'b0, '0);
    drain();

    // Output stall for 5 cycles with continuous input: 20 in, 20 out, data held.
    n0 = n_out; acc_cnt = 0; held_v = 1'b0; held = '0;
    for (int k = 0; k < 60 && acc_cnt < 20; k++) begin
      logic rdy;
      rdy = !(k >= 5 && k < 10);
      cycle('1, '1, rvec(), rvec(), 2'($urandom), 1'b0, '0, rdy, a);
      if (a) acc_cnt++;
      if (k >= 5 && k < 10) begin
        check("stall_sink_ready", 64'(bus.sink_ready), 64'(0));
        if (held_v) check("stall_hold_data", 64'(bus.src_data), 64'(held));
        else begin held = bus.src_data; held_v = 1'b1; end
        check("stall_hold_valid", 64'(bus.src_valid), 64'(1));
      end
    end
    check("stall_accepts", 64'(acc_cnt), 64'(20));
    drain();
    check("stall_frames_out", 64'(n_out - n0), 64'(20));

    // Partial valids are ignored; completing them next cycle yields one frame.
    n0 = n_out;
    dd = rvec(); wd = rvec();
    cycle(2'b11, 2'b01, dd, wd, 2'b00, 1'b0, '0, 1'b1, a);
    repeat (3) idle(1'b1);
    check("partial_no_output", 64'(n_out - n0), 64'(0));
    cycle(2'b11, 2'b11, dd, wd, 2'b00, 1'b0, '0, 1'b1, a);
    drain();
    check("partial_one_frame", 64'(n_out - n0), 64'(1));

    // Coefficient load coincident with accept applies to the following frame.
    cycle('0, '0, '0, '0, 2'b00, 1'b1, 24'h400000, 1'b1, a);
    frame(rvec(), rvec(), 2'b00, 1'b1, '0);
    frame(rvec(), rvec(), 2'b00, 1'b0, '0);
    drain();

    // Reset with two frames in flight.
    cycle('0, '0, '0, '0, 2'b00, 1'b1, 24'h123456, 1'b1, a);
    frame(rvec(), rvec(), 2'b00, 1'b0, '0);
    frame(rvec(), rvec(), 2'b00, 1'b0, '0);
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    mix_m = MIX_DEFAULT;
    #1;
    check("rst_mid_src_valid", 64'(bus.src_valid), 64'(0));
    check("rst_mid_src_data", 64'(bus.src_data), 64'(0));
    repeat (2) idle(1'b1);
    reset_n = 1'b1;
    n0 = n_out;
    repeat (3) idle(1'b1);
    check("post_rst_no_stale", 64'(n_out - n0), 64'(0));
    check("post_rst_src_valid", 64'(bus.src_valid), 64'(0));
    frame({24'd1000, 24'hfffc18}, {24'd3000, 24'd5000}, 2'b00, 1'b0, '0);
    drain();

    // Randomized traffic: partial valids, modes, coefficient loads, backpressure.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] dv, wv;
      dv = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      wv = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      cycle(dv, wv, rvec(), rvec(), 2'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0) ? '1 : CW'($urandom),
            ($urandom_range(0, 3) != 0), a);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
